// File: rtl/tone_sample_gen_pkg.sv
// tone_sample_gen_pkg
// Shared definitions for the tone sample generator: the tone FSM state
// enumeration, the default tone parameters and a small helper used to size
// the internal counters.
package tone_sample_gen_pkg;

    // Tone generator states: silence, hit tone, game-over tone, and the
    // post-game-over hold that waits for fin_juego to drop.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIT    = 2'd1,
        ST_END    = 2'd2,
        ST_SILENT = 2'd3
    } tone_state_t;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_AMP      = 16'h2000;
    localparam int DEF_HIT_HALF = 24;
    localparam int DEF_END_HALF = 60;
    localparam int DEF_HIT_LEN  = 4800;
    localparam int DEF_END_LEN  = 24000;

    // Larger of two sizes, used to share one counter between both tones.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// tone_osc
// Square-wave oscillator core: a half-period counter that counts 0..half-1
// on each advance and toggles the phase when it wraps.
//   clk       : clock
//   reset     : synchronous active-low reset
//   clear     : restart the waveform (counter 0, phase positive)
//   advance   : one sample period has elapsed
//   half      : half-period length in sample periods (must be >= 1)
//   phase_neg : 0 = positive half-wave, 1 = negative half-wave
module tone_osc #(
    parameter int HALF_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [HALF_W-1:0] half,
    output logic              phase_neg
);

    logic [HALF_W-1:0] half_cnt;

    // Clear wins over advance so a retrigger arriving together with a
    // sample request restarts the waveform cleanly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            half_cnt  <= '0;
            phase_neg <= 1'b0;
        end else if (clear) begin
            half_cnt  <= '0;
            phase_neg <= 1'b0;
        end else if (advance) begin
            if (half_cnt == half - HALF_W'(1)) begin
                half_cnt  <= '0;
                phase_neg <= ~phase_neg;
            end else begin
                half_cnt <= half_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_sample_gen.sv
// tone_sample_gen
// Produces the audio samples fed to the I2S transmitter: a short square-wave
// hit tone on pulso_sonar, and a longer game-over tone on a rising edge of
// fin_juego whose amplitude halves every quarter of its duration.
//   clk          : clock
//   reset        : synchronous active-low reset
//   pulso_sonar  : one-cycle strobe requesting the hit tone
//   fin_juego    : game-over level
//   sample_req   : one-cycle strobe per stereo frame from the I2S transmitter
//   sample       : signed sample for both channels, held between updates
//   sample_valid : one-cycle qualifier, the cycle after sample_req
//   busy         : high while the hit or game-over tone is playing
module tone_sample_gen
    import tone_sample_gen_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int AMP      = DEF_AMP,
    parameter int HIT_HALF = DEF_HIT_HALF,
    parameter int END_HALF = DEF_END_HALF,
    parameter int HIT_LEN  = DEF_HIT_LEN,
    parameter int END_LEN  = DEF_END_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pulso_sonar,
    input  logic                       fin_juego,
    input  logic                       sample_req,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       busy
);

    localparam int HALF_W  = $clog2(max_int(HIT_HALF, END_HALF) + 1);
    localparam int DUR_W   = $clog2(max_int(HIT_LEN, END_LEN) + 1);
    localparam int QUARTER = END_LEN / 4;
    localparam logic [SAMPLE_W-1:0] AMP_W = SAMPLE_W'(AMP);

    tone_state_t       state, state_next;
    logic [DUR_W-1:0]  dur_cnt, dur_next;
    logic              fin_prev;
    logic              fin_rise;
    logic              osc_clear, osc_adv;
    logic              phase_neg;
    logic [HALF_W-1:0] half_sel;
    logic [SAMPLE_W-1:0] mag, raw_sample;

    assign fin_rise = fin_juego & ~fin_prev;
    assign half_sel = (state == ST_END) ? HALF_W'(END_HALF) : HALF_W'(HIT_HALF);

    tone_osc #(.HALF_W(HALF_W)) u_osc (
        .clk       (clk),
        .reset     (reset),
        .clear     (osc_clear),
        .advance   (osc_adv),
        .half      (half_sel),
        .phase_neg (phase_neg)
    );

    // Next-state logic. A game-over edge beats a simultaneous hit strobe;
    // the waveform only moves on sample requests while a tone is playing.
    always_comb begin
        state_next = state;
        dur_next   = dur_cnt;
        osc_clear  = 1'b0;
        osc_adv    = 1'b0;
        case (state)
            ST_IDLE, ST_HIT: begin
                if (fin_rise) begin
                    state_next = ST_END;
                    dur_next   = '0;
                    osc_clear  = 1'b1;
                end else if (pulso_sonar) begin
                    state_next = ST_HIT;
                    dur_next   = '0;
                    osc_clear  = 1'b1;
                end else if (state == ST_HIT && sample_req) begin
                    osc_adv = 1'b1;
                    if (dur_cnt == DUR_W'(HIT_LEN - 1)) begin
                        state_next = ST_IDLE;
                        dur_next   = '0;
                    end else begin
                        dur_next = dur_cnt + DUR_W'(1);
                    end
                end
            end
            ST_END: begin
                if (sample_req) begin
                    osc_adv = 1'b1;
                    if (dur_cnt == DUR_W'(END_LEN - 1)) begin
                        state_next = ST_SILENT;
                        dur_next   = '0;
                    end else begin
                        dur_next = dur_cnt + DUR_W'(1);
                    end
                end
            end
            ST_SILENT: begin
                if (!fin_juego) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample value from the current (pre-update) state. The game-over tone
    // decays by one octave of amplitude (a right shift) each quarter, using
    // threshold compares instead of a divide.
    always_comb begin
        mag = '0;
        case (state)
            ST_HIT: mag = AMP_W;
            ST_END: begin
                if (dur_cnt >= DUR_W'(3 * QUARTER))      mag = AMP_W >> 3;
                else if (dur_cnt >= DUR_W'(2 * QUARTER)) mag = AMP_W >> 2;
                else if (dur_cnt >= DUR_W'(QUARTER))     mag = AMP_W >> 1;
                else                                     mag = AMP_W;
            end
            default: mag = '0;
        endcase
        raw_sample = phase_neg ? (-mag) : mag;
    end

    // State, counters and registered outputs. busy follows the next state so
    // it reflects the state register from the same edge onward.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            dur_cnt      <= '0;
            fin_prev     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            dur_cnt      <= dur_next;
            fin_prev     <= fin_juego;
            sample_valid <= sample_req;
            busy         <= (state_next == ST_HIT) || (state_next == ST_END);
            if (sample_req) begin
                sample <= raw_sample;
            end
        end
    end

endmodule

// File: tb/tb_tone_sample_gen.sv
// tb_tone_sample_gen
// Self-checking bench for tone_sample_gen with small tone parameters.
// A behavioural model tracks which tone is playing and how many samples of
// it have been emitted; expected samples come from closed-form arithmetic.
module tb_tone_sample_gen;

    localparam int SW = 16;
    localparam int AMP = 100;
    localparam int HH = 2;
    localparam int EH = 3;
    localparam int HL = 8;
    localparam int EL = 12;

    localparam int M_IDLE = 0;
    localparam int M_HIT = 1;
    localparam int M_END = 2;
    localparam int M_SILENT = 3;

    logic clk = 1'b0;
    logic reset;
    logic pulso_sonar;
    logic fin_juego;
    logic sample_req;
    logic signed [SW-1:0] sample;
    logic sample_valid;
    logic busy;

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_n;
    bit m_fin_prev;
    int m_sample;
    bit m_valid;

    always #5 clk = ~clk;

    tone_sample_gen #(
        .SAMPLE_W (SW),
        .AMP      (AMP),
        .HIT_HALF (HH),
        .END_HALF (EH),
        .HIT_LEN  (HL),
        .END_LEN  (EL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pulso_sonar  (pulso_sonar),
        .fin_juego    (fin_juego),
        .sample_req   (sample_req),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // Sample n (0-based) of a tone: sign flips every half period, and the
    // game-over tone's amplitude halves every quarter of its length.
    function automatic int ref_sample(input int mode, input int n);
        int mag;
        bit neg;
        mag = 0;
        neg = 1'b0;
        if (mode == M_HIT) begin
            mag = AMP;
            neg = ((n / HH) % 2) == 1;
        end else if (mode == M_END) begin
            mag = AMP >> (n / (EL / 4));
            neg = ((n / EH) % 2) == 1;
        end
        return neg ? -mag : mag;
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; the model advances alongside the DUT and
    // all outputs are compared 1 time unit after the edge.
    task automatic applyStimulus(input bit p, input bit f, input bit r);
        bit rise;
        pulso_sonar = p;
        fin_juego   = f;
        sample_req  = r;
        if (r) m_sample = ref_sample(m_mode, m_n);
        m_valid = r;
        rise = f && !m_fin_prev;
        if ((m_mode == M_IDLE || m_mode == M_HIT) && rise) begin
            m_mode = M_END;
            m_n    = 0;
        end else if ((m_mode == M_IDLE || m_mode == M_HIT) && p) begin
            m_mode = M_HIT;
            m_n    = 0;
        end else if (m_mode == M_HIT && r) begin
            m_n++;
            if (m_n == HL) begin
                m_mode = M_IDLE;
                m_n    = 0;
            end
        end else if (m_mode == M_END && r) begin
            m_n++;
            if (m_n == EL) begin
                m_mode = M_SILENT;
                m_n    = 0;
            end
        end else if (m_mode == M_SILENT && !f) begin
            m_mode = M_IDLE;
        end
        m_fin_prev = f;
        @(posedge clk);
        #1;
        checkOutput("sample_valid", int'(sample_valid), int'(m_valid));
        checkOutput("sample", int'(sample), m_sample);
        checkOutput("busy", int'(busy), int'(m_mode == M_HIT || m_mode == M_END));
        pulso_sonar = 1'b0;
        sample_req  = 1'b0;
    endtask

    // One reset cycle; fin_juego keeps its current level across it.
    task automatic doReset();
        reset = 1'b0;
        pulso_sonar = 1'b0;
        sample_req  = 1'b0;
        @(posedge clk);
        #1;
        m_mode = M_IDLE;
        m_n = 0;
        m_fin_prev = 1'b0;
        m_sample = 0;
        m_valid = 1'b0;
        checkOutput("reset_sample", int'(sample), 0);
        checkOutput("reset_valid", int'(sample_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        reset = 1'b1;
    endtask

    // A sample request followed by a gap cycle, also compared to a fixed table.
    task automatic reqExpect(input string tag, input int exp);
        applyStimulus(1'b0, fin_juego, 1'b1);
        checkOutput(tag, int'(sample), exp);
        applyStimulus(1'b0, fin_juego, 1'b0);
    endtask

    initial begin
        int hit_tab[10];
        int end_tab[12];
        bit rf;
        hit_tab = '{100, 100, -100, -100, 100, 100, -100, -100, 0, 0};
        end_tab = '{100, 100, 100, -50, -50, -50, 25, 25, 25, -12, -12, -12};

        fin_juego = 1'b0;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Hit tone, then silence after its eight samples.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) reqExpect("hit_table", hit_tab[i]);
        checkOutput("hit_busy_done", int'(busy), 0);

        // Game-over tone from idle, then silent hold until fin_juego drops.
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) reqExpect("end_table", end_tab[i]);
        reqExpect("silent_sample", 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        reqExpect("after_silent_hit", 100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doReset();

        // Simultaneous hit strobe and game-over edge; hit ignored during END.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) applyStimulus(1'b1, 1'b1, 1'b0);
            reqExpect("end_prio_table", end_tab[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Retrigger after five hit samples restarts the waveform.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) reqExpect("pre_retrig", hit_tab[i]);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) reqExpect("retrig_table", hit_tab[i]);

        // Reset mid-tone, then back-to-back requests.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) reqExpect("pre_reset", hit_tab[i]);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_sample", int'(sample), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);

        // fin_juego held high through reset counts as an edge afterwards.
        fin_juego = 1'b1;
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        reqExpect("fin_thru_reset", 100);
        checkOutput("fin_thru_reset_busy", int'(busy), 1);

        // Randomised traffic against the model.
        rf = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) rf = ~rf;
            if ($urandom_range(0, 199) == 0) begin
                fin_juego = rf;
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 11) == 0, rf,
                              $urandom_range(0, 2) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_sample_gen.md
TONE_SAMPLE_GEN -- requirements
Module: tone_sample_gen

Interface
REQ-001 The module SHALL have parameter SAMPLE_W, default 16, meaning the width of the signed two's-complement output sample.
REQ-002 The module SHALL have parameter AMP, default 16'h2000, meaning the peak tone amplitude (positive; AMP < 2^(SAMPLE_W-1)).
REQ-003 The module SHALL have parameter HIT_HALF, default 24, meaning the hit-tone half-period in sample periods.
REQ-004 The module SHALL have parameter END_HALF, default 60, meaning the game-over-tone half-period in sample periods.
REQ-005 The module SHALL have parameter HIT_LEN, default 4800, meaning the hit-tone duration in sample periods.
REQ-006 The module SHALL have parameter END_LEN, default 24000, meaning the game-over-tone duration in sample periods (multiple of 4).
REQ-007 Port clk, input, 1 bit: the single clock.
REQ-008 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-009 Port pulso_sonar, input, 1 bit: one-cycle game-event strobe requesting the hit tone.
REQ-010 Port fin_juego, input, 1 bit: game-over level.
REQ-011 Port sample_req, input, 1 bit: one-cycle strobe from the I2S transmitter, one per stereo frame.
REQ-012 Port sample, output, SAMPLE_W bits: signed sample for both channels.
REQ-013 Port sample_valid, output, 1 bit: one-cycle qualifier for sample.
REQ-014 Port busy, output, 1 bit: high while a tone is playing (HIT or END).

Function
REQ-015 The FSM SHALL have states IDLE, HIT, END, SILENT.
REQ-016 From IDLE, pulso_sonar=1 SHALL transition to HIT, clearing the duration counter, half-period counter and phase (phase = positive).
REQ-017 In HIT, pulso_sonar=1 SHALL retrigger: the duration, half-period and phase counters clear and the state stays HIT.
REQ-018 A fin_juego rising edge (registered previous value 0, current 1) SHALL transition from any of IDLE or HIT to END, clearing all counters; this takes priority over a simultaneous pulso_sonar.
REQ-019 In END and SILENT, pulso_sonar SHALL be ignored.
REQ-020 Counters SHALL advance only on sample_req cycles; the duration counter increments once per sample_req.
REQ-021 The half-period counter SHALL count 0..H-1 (H = HIT_HALF or END_HALF by state); on the sample_req where it equals H-1 it wraps to 0 and phase toggles.
REQ-022 HIT SHALL return to IDLE on the sample_req where the duration counter equals HIT_LEN-1.
REQ-023 END SHALL go to SILENT on the sample_req where the duration counter equals END_LEN-1.
REQ-024 SILENT SHALL go to IDLE when fin_juego=0.
REQ-025 On each sample_req, the cycle after SHALL have sample_valid=1 for exactly one cycle, with sample computed from state/phase/counters as they were in the sample_req cycle (pre-update).
REQ-026 Sample value: IDLE/SILENT = 0; HIT = +AMP if phase positive else -AMP; END = ±(AMP >> k), k = duration_count / (END_LEN/4), k in 0..3.
REQ-027 Negative values SHALL be exact two's-complement negation, computed at width SAMPLE_W.
REQ-028 sample SHALL hold its last value between sample_valid pulses.
REQ-029 busy SHALL be a registered output equal to (state == HIT or END).
REQ-030 Back-to-back sample_req on consecutive cycles SHALL each produce one sample_valid pulse.

Reset
REQ-031 On clk edge with reset=0: state=IDLE, all counters=0, phase=positive, fin_juego history=0, sample=0, sample_valid=0, busy=0.
REQ-032 Reset mid-tone SHALL abort the tone with no further nonzero samples; a fin_juego held high through reset release SHALL count as a rising edge on the first cycle after release.

Structure
REQ-033 A shared package SHALL hold the state enumeration and default parameter constants (AMP, HIT_HALF, END_HALF, HIT_LEN, END_LEN).
REQ-034 One sub-module, tone_osc (half-period counter + phase toggle, inputs clear/advance/half), SHALL be instantiated once.
REQ-035 The block sits directly upstream of the I2S transmitter; the top level connects the game-event strobe and game-over level to it.

Verification (HIT_HALF=2, END_HALF=3, HIT_LEN=8, END_LEN=12, AMP=100)
REQ-036 pulso_sonar, then 10 sample_req -> samples +100,+100,-100,-100,+100,+100,-100,-100,0,0; busy drops after the 8th sample_req.
REQ-037 fin_juego rises in IDLE, 12 sample_req -> +100,+100,+100,-50,-50,-50,+25,+25,+25,-12,-12,-12; state SILENT; fin_juego=0 -> IDLE.
REQ-038 pulso_sonar and fin_juego rise in the same cycle -> END sequence of REQ-037; pulso_sonar during END -> no change.
REQ-039 pulso_sonar retrigger after 5 sample_req in HIT -> the following 8 samples repeat +100,+100,-100,-100,...
REQ-040 reset=0 after 3 HIT samples -> next sample_req yields 0, busy=0; sample_req on consecutive cycles -> consecutive sample_valid pulses.
